axi_master_wr_engine: RTL and testbench

- Parametrised AXI4 write-master engine. Next generation of the team's AXI master write control path.
- Accepts burst commands from the decoder and streams write data onto the W channel. Collects B responses and returns one response per burst to the decoder.
- Unlike the previous single-transaction FSM:
  - supports up to MAX_OUTST outstanding write bursts, with AW issued ahead of W;
  - has configurable ID, address and data widths;
  - flags protocol errors.

---
 rtl/axi_master_wr_engine_if.sv | 35 +++
 rtl/axi_master_wr_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_master_wr_engine.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_wr_engine_if.sv
// AXI4 write-channel bundle (AW, W, B) between the write engine and the slave.
interface axi_master_wr_engine_if #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );
endinterface

// File: rtl/axi_master_wr_engine.sv
// AXI4 write-master engine: multiple outstanding bursts, AW ahead of W, one response per burst.
// Optional WR_BOUNDARY_CHECK_EN: INCR bursts crossing 4 KB are answered locally with SLVERR.
module axi_master_wr_engine #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                      AClk,
    input  logic                      ARst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    input  logic [ID_WIDTH-1:0]       cmd_id,
    input  logic                      wd_valid,
    output logic                      wd_ready,
    input  logic [DATA_WIDTH-1:0]     wd_data,
    input  logic [DATA_WIDTH/8-1:0]   wd_strb,
    axi_master_wr_engine_if.master    axi,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_WIDTH-1:0]       rsp_id,
    output logic [1:0]                rsp_resp,
    output logic [$clog2(MAX_OUTST):0] outst_cnt,
    output logic                      err_unexp_b
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTST);

    typedef enum logic {AW_IDLE, AW_VALID} aw_state_e;

    aw_state_e state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic [ID_WIDTH-1:0]   awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [2:0]            awsize_q, awsize_d;
    logic [1:0]            awburst_q, awburst_d;
    logic [7:0]            beat_q, beat_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic                  err_q, err_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [7:0]            len_mem_q [MAX_OUTST];

    logic fifo_empty_c, fifo_full_c, cmd_hs_c, issue_c, w_hs_c, wlast_c, bready_c, b_hs_c;

`ifdef WR_BOUNDARY_CHECK_EN
    logic                loc_pend_q, loc_pend_d;
    logic [ID_WIDTH-1:0] loc_id_q, loc_id_d;
    logic [23:0]         end_off_c;
    logic                cross_c;

    // Offset of the last byte relative to the start address's 4 KB page
    always_comb begin
        end_off_c = 24'(cmd_addr[11:0]) + (24'({1'b0, cmd_len} + 9'd1) << cmd_size) - 24'd1;
        cross_c   = (cmd_burst == 2'b01) && (end_off_c[23:12] != 12'd0);
    end

    assign cmd_ready = (state_q == AW_IDLE) && (outst_q < CNT_W'(MAX_OUTST)) && !fifo_full_c
                       && !loc_pend_q;
    assign issue_c   = cmd_hs_c && !cross_c;
    assign bready_c  = (!rsp_valid_q || rsp_ready) && !loc_pend_q;
`else
    assign cmd_ready = (state_q == AW_IDLE) && (outst_q < CNT_W'(MAX_OUTST)) && !fifo_full_c;
    assign issue_c   = cmd_hs_c;
    assign bready_c  = !rsp_valid_q || rsp_ready;
`endif

    assign fifo_empty_c = (fifo_cnt_q == '0);
    assign fifo_full_c  = (fifo_cnt_q == CNT_W'(MAX_OUTST));
    assign cmd_hs_c     = cmd_valid && cmd_ready;
    assign w_hs_c       = wd_valid && axi.WREADY && !fifo_empty_c;
    assign wlast_c      = !fifo_empty_c && (beat_q == len_mem_q[rd_ptr_q]);
    assign b_hs_c       = axi.BVALID && bready_c;

    assign wd_ready    = axi.WREADY && !fifo_empty_c;
    assign axi.WVALID  = wd_valid && !fifo_empty_c;
    assign axi.WDATA   = wd_data;
    assign axi.WSTRB   = wd_strb;
    assign axi.WLAST   = wlast_c;
    assign axi.BREADY  = bready_c;
    assign axi.AWVALID = awvalid_q;
    assign axi.AWID    = awid_q;
    assign axi.AWADDR  = awaddr_q;
    assign axi.AWLEN   = awlen_q;
    assign axi.AWSIZE  = awsize_q;
    assign axi.AWBURST = awburst_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_resp    = rsp_resp_q;
    assign outst_cnt   = outst_q;
    assign err_unexp_b = err_q;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        awid_d      = awid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        awburst_d   = awburst_q;
        beat_d      = beat_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef WR_BOUNDARY_CHECK_EN
        loc_pend_d  = loc_pend_q;
        loc_id_d    = loc_id_q;
`endif

        // AW channel: capture on accept, hold until the slave takes it
        case (state_q)
            AW_IDLE: if (issue_c) begin
                state_d   = AW_VALID;
                awvalid_d = 1'b1;
                awid_d    = cmd_id;
                awaddr_d  = cmd_addr;
                awlen_d   = cmd_len;
                awsize_d  = cmd_size;
                awburst_d = cmd_burst;
            end
            AW_VALID: if (axi.AWREADY) begin
                state_d   = AW_IDLE;
                awvalid_d = 1'b0;
            end
            default: state_d = AW_IDLE;
        endcase

        // Beat counting against the head-of-queue burst length
        if (w_hs_c) beat_d = wlast_c ? 8'd0 : beat_q + 8'd1;
        if (issue_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_hs_c && wlast_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        fifo_cnt_d = fifo_cnt_q + CNT_W'(issue_c) - CNT_W'(w_hs_c && wlast_c);

        // A B with nothing outstanding is flagged and never decrements
        if (b_hs_c && (outst_q == '0)) err_d = 1'b1;
        outst_d = outst_q + CNT_W'(issue_c) - CNT_W'(b_hs_c && (outst_q != '0));

        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        if (b_hs_c) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = axi.BID;
            rsp_resp_d  = axi.BRESP;
        end
`ifdef WR_BOUNDARY_CHECK_EN
        else if (loc_pend_q && (!rsp_valid_q || rsp_ready)) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = loc_id_q;
            rsp_resp_d  = 2'b10;
            loc_pend_d  = 1'b0;
        end
        if (cmd_hs_c && cross_c) begin
            loc_pend_d = 1'b1;
            loc_id_d   = cmd_id;
        end
`endif
    end

    always_ff @(posedge AClk) begin
        if (!ARst) begin
            state_q     <= AW_IDLE;
            awvalid_q   <= 1'b0;
            awid_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            beat_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_resp_q  <= '0;
`ifdef WR_BOUNDARY_CHECK_EN
            loc_pend_q  <= 1'b0;
            loc_id_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            awid_q      <= awid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            awburst_q   <= awburst_d;
            beat_q      <= beat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef WR_BOUNDARY_CHECK_EN
            loc_pend_q  <= loc_pend_d;
            loc_id_q    <= loc_id_d;
`endif
        end
    end

    // Burst-length queue storage; validity is tracked by the pointers above
    always_ff @(posedge AClk) begin
        if (issue_c) len_mem_q[wr_ptr_q] <= cmd_len;
    end
endmodule

// File: tb/tb_axi_master_wr_engine.sv
// Directed self-checking bench for axi_master_wr_engine (default parameters).
module tb_axi_master_wr_engine;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned MO = 4;

    logic          AClk, ARst;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_burst;
    logic [IW-1:0] cmd_id;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic [DW/8-1:0] wd_strb;
    logic          rsp_valid, rsp_ready;
    logic [IW-1:0] rsp_id;
    logic [1:0]    rsp_resp;
    logic [$clog2(MO):0] outst_cnt;
    logic          err_unexp_b;

    int checks = 0;
    int errors = 0;
    int aw_hs_cnt = 0;

    axi_master_wr_engine_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_if ();

    axi_master_wr_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTST(MO)) dut (
        .AClk(AClk), .ARst(ARst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .axi(axi_if),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
        .outst_cnt(outst_cnt), .err_unexp_b(err_unexp_b)
    );

    initial begin
        AClk = 1'b0;
        forever #5 AClk = ~AClk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // AW handshakes counted from stable mid-cycle values
    always @(negedge AClk) begin
        #2;
        if (ARst && axi_if.AWVALID && axi_if.AWREADY) aw_hs_cnt++;
    end

    task automatic do_reset();
        @(negedge AClk);
        ARst = 1'b0;
        cmd_valid = 1'b0; wd_valid = 1'b0; rsp_ready = 1'b1;
        axi_if.AWREADY = 1'b1; axi_if.WREADY = 1'b1; axi_if.BVALID = 1'b0;
        axi_if.BID = '0; axi_if.BRESP = '0;
        repeat (2) @(negedge AClk);
        ARst = 1'b1;
    endtask

    // Presents a command until accepted or maxcyc cycles pass; returns at a falling edge
    task automatic drive_cmd(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic [IW-1:0] id, input int maxcyc,
                             output bit ok);
        ok = 1'b0;
        @(negedge AClk);
        cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_id = id;
        cmd_valid = 1'b1;
        for (int i = 0; i < maxcyc && !ok; i++) begin
            #1;
            if (cmd_ready) ok = 1'b1;
            @(negedge AClk);
        end
        cmd_valid = 1'b0;
    endtask

    // Streams nbeats W beats (data = 100+beat); optional WREADY toggling
    task automatic run_w(input int nbeats, input bit toggle, output int seen, output int nlast,
                         output int last_idx, output int data_bad);
        seen = 0; nlast = 0; last_idx = 0; data_bad = 0;
        for (int cyc = 0; cyc < 200 && seen < nbeats; cyc++) begin
            @(negedge AClk);
            if (toggle) axi_if.WREADY = (cyc % 2 == 1);
            wd_valid = 1'b1;
            wd_data  = DW'(seen + 100);
            wd_strb  = '1;
            #1;
            if (axi_if.WVALID && axi_if.WREADY) begin
                if (axi_if.WLAST) begin nlast++; last_idx = seen + 1; end
                if (axi_if.WDATA !== DW'(seen + 100) || axi_if.WSTRB !== '1 || !wd_ready) data_bad++;
                seen++;
            end
        end
        @(negedge AClk);
        wd_valid = 1'b0;
        axi_if.WREADY = 1'b1;
    endtask

    task automatic send_b(input logic [IW-1:0] id, input logic [1:0] resp, input int maxcyc,
                          output bit ok);
        ok = 1'b0;
        @(negedge AClk);
        axi_if.BVALID = 1'b1; axi_if.BID = id; axi_if.BRESP = resp;
        for (int i = 0; i < maxcyc && !ok; i++) begin
            #1;
            if (axi_if.BREADY) ok = 1'b1;
            @(negedge AClk);
        end
        axi_if.BVALID = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        wd_valid = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0h exp 1", cmd_ready); end
        checks++; if (axi_if.AWVALID !== 1'b0) begin errors++; $display("FAIL reset_awvalid got %0h exp 0", axi_if.AWVALID); end
        checks++; if (outst_cnt !== '0) begin errors++; $display("FAIL reset_outst got %0d exp 0", outst_cnt); end
        checks++; if (rsp_valid !== 1'b0 || err_unexp_b !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %0h/%0h exp 0/0", rsp_valid, err_unexp_b); end
        checks++; if (axi_if.WVALID !== 1'b0 || wd_ready !== 1'b0) begin errors++; $display("FAIL reset_w_gated got %0h/%0h exp 0/0", axi_if.WVALID, wd_ready); end
        checks++; if (axi_if.BREADY !== 1'b1) begin errors++; $display("FAIL reset_bready got %0h exp 1", axi_if.BREADY); end
        wd_valid = 1'b0;
    endtask

    task automatic test_single_burst();
        bit ok; int seen, nlast, lidx, dbad;
        do_reset();
        drive_cmd(32'h1000, 8'd3, 3'd3, 2'b01, 4'd5, 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept got 0 exp 1"); end
        #1;
        checks++; if (axi_if.AWVALID !== 1'b1 || axi_if.AWADDR !== 32'h1000) begin errors++; $display("FAIL single_aw got v=%0h a=%0h exp v=1 a=1000", axi_if.AWVALID, axi_if.AWADDR); end
        checks++; if (axi_if.AWLEN !== 8'd3 || axi_if.AWSIZE !== 3'd3 || axi_if.AWID !== 4'd5 || axi_if.AWBURST !== 2'b01) begin errors++; $display("FAIL single_aw_fields got len=%0d size=%0d id=%0d burst=%0d exp 3/3/5/1", axi_if.AWLEN, axi_if.AWSIZE, axi_if.AWID, axi_if.AWBURST); end
        checks++; if (outst_cnt !== 3'd1) begin errors++; $display("FAIL single_outst_inc got %0d exp 1", outst_cnt); end
        @(negedge AClk); #1;
        checks++; if (axi_if.AWVALID !== 1'b0) begin errors++; $display("FAIL single_aw_one_cycle got %0h exp 0", axi_if.AWVALID); end
        run_w(4, 1'b0, seen, nlast, lidx, dbad);
        checks++; if (seen !== 4 || nlast !== 1 || lidx !== 4 || dbad !== 0) begin errors++; $display("FAIL single_w got beats=%0d lasts=%0d lastbeat=%0d bad=%0d exp 4/1/4/0", seen, nlast, lidx, dbad); end
        send_b(4'd5, 2'b00, 4, ok);
        #1;
        checks++; if (!ok || rsp_valid !== 1'b1 || rsp_id !== 4'd5 || rsp_resp !== 2'b00) begin errors++; $display("FAIL single_rsp got ok=%0d v=%0h id=%0d resp=%0d exp 1/1/5/0", ok, rsp_valid, rsp_id, rsp_resp); end
        checks++; if (outst_cnt !== '0) begin errors++; $display("FAIL single_outst_dec got %0d exp 0", outst_cnt); end
        @(negedge AClk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_clear got %0h exp 0", rsp_valid); end
    endtask

    task automatic test_outstanding_limit();
        bit ok; int acc, seen, nlast, lidx, dbad;
        do_reset();
        aw_hs_cnt = 0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(AW'(32'h4000 + i * 8), 8'd0, 3'd3, 2'b01, IW'(i), 6, ok);
            if (ok) acc++;
        end
        #1;
        checks++; if (acc !== 4 || aw_hs_cnt !== 4) begin errors++; $display("FAIL limit_accepts got acc=%0d aw=%0d exp 4/4", acc, aw_hs_cnt); end
        checks++; if (outst_cnt !== 3'd4 || cmd_ready !== 1'b0) begin errors++; $display("FAIL limit_full got outst=%0d rdy=%0h exp 4/0", outst_cnt, cmd_ready); end
        run_w(4, 1'b0, seen, nlast, lidx, dbad);
        #1;
        checks++; if (seen !== 4 || nlast !== 4) begin errors++; $display("FAIL limit_w got beats=%0d lasts=%0d exp 4/4", seen, nlast); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL limit_outst_blocks got %0h exp 0", cmd_ready); end
        send_b(4'd0, 2'b00, 4, ok);
        #1;
        checks++; if (!ok || outst_cnt !== 3'd3 || cmd_ready !== 1'b1) begin errors++; $display("FAIL limit_release got ok=%0d outst=%0d rdy=%0h exp 1/3/1", ok, outst_cnt, cmd_ready); end
        drive_cmd(32'h4100, 8'd0, 3'd3, 2'b01, 4'd4, 4, ok);
        #1;
        checks++; if (!ok || outst_cnt !== 3'd4) begin errors++; $display("FAIL limit_fifth got ok=%0d outst=%0d exp 1/4", ok, outst_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok; int bad, seen, nlast, lidx, dbad;
        do_reset();
        axi_if.AWREADY = 1'b0;
        drive_cmd(32'h2000, 8'd7, 3'd3, 2'b01, 4'd3, 4, ok);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!(axi_if.AWVALID === 1'b1 && axi_if.AWADDR === 32'h2000 && axi_if.AWLEN === 8'd7
                  && axi_if.AWID === 4'd3 && cmd_ready === 1'b0)) bad++;
            @(negedge AClk);
        end
        checks++; if (!ok || bad !== 0) begin errors++; $display("FAIL bp_aw_stable got ok=%0d unstable=%0d exp 1/0", ok, bad); end
        run_w(8, 1'b1, seen, nlast, lidx, dbad);
        checks++; if (seen !== 8 || nlast !== 1 || lidx !== 8 || dbad !== 0) begin errors++; $display("FAIL bp_w got beats=%0d lasts=%0d lastbeat=%0d bad=%0d exp 8/1/8/0", seen, nlast, lidx, dbad); end
        wd_valid = 1'b1;
        #1;
        checks++; if (axi_if.WVALID !== 1'b0) begin errors++; $display("FAIL bp_no_extra_beat got %0h exp 0", axi_if.WVALID); end
        @(negedge AClk);
        wd_valid = 1'b0;
        axi_if.AWREADY = 1'b1;
        @(negedge AClk); #1;
        checks++; if (axi_if.AWVALID !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_aw_done got v=%0h rdy=%0h exp 0/1", axi_if.AWVALID, cmd_ready); end
    endtask

    task automatic test_rsp_stall();
        bit ok; int seen, nlast, lidx, dbad, bad, ng, bnext, first, lastc;
        logic [IW-1:0] got [3];
        do_reset();
        for (int i = 1; i <= 3; i++) drive_cmd(AW'(32'h6000 + i * 8), 8'd0, 3'd3, 2'b01, IW'(i), 4, ok);
        run_w(3, 1'b0, seen, nlast, lidx, dbad);
        rsp_ready = 1'b0;
        send_b(4'd1, 2'b00, 4, ok);
        axi_if.BVALID = 1'b1; axi_if.BID = 4'd2; axi_if.BRESP = 2'b00;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (axi_if.BREADY !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 4'd1) bad++;
            @(negedge AClk);
        end
        checks++; if (!ok || bad !== 0) begin errors++; $display("FAIL stall_bready got ok=%0d bad=%0d exp 1/0", ok, bad); end
        rsp_ready = 1'b1;
        ng = 0; bnext = 2; first = -1; lastc = -1;
        for (int cyc = 0; cyc < 20 && ng < 3; cyc++) begin
            axi_if.BVALID = (bnext <= 3);
            axi_if.BID = IW'(bnext);
            #1;
            if (rsp_valid && rsp_ready) begin
                got[ng] = rsp_id;
                if (ng == 0) first = cyc;
                lastc = cyc;
                ng++;
            end
            if (axi_if.BVALID && axi_if.BREADY) bnext++;
            @(negedge AClk);
        end
        axi_if.BVALID = 1'b0;
        #1;
        checks++; if (ng !== 3 || got[0] !== 4'd1 || got[1] !== 4'd2 || got[2] !== 4'd3) begin errors++; $display("FAIL stall_order got n=%0d ids=%0d,%0d,%0d exp 3 ids=1,2,3", ng, got[0], got[1], got[2]); end
        checks++; if (lastc - first !== 2) begin errors++; $display("FAIL stall_b2b got span=%0d exp 2", lastc - first); end
        checks++; if (outst_cnt !== '0) begin errors++; $display("FAIL stall_outst got %0d exp 0", outst_cnt); end
    endtask

    task automatic test_unexp_b();
        bit ok;
        do_reset();
        send_b(4'd7, 2'b01, 4, ok);
        #1;
        checks++; if (!ok || err_unexp_b !== 1'b1 || outst_cnt !== '0) begin errors++; $display("FAIL unexp_flag got ok=%0d err=%0h outst=%0d exp 1/1/0", ok, err_unexp_b, outst_cnt); end
        checks++; if (rsp_id !== 4'd7 || rsp_resp !== 2'b01) begin errors++; $display("FAIL unexp_rsp got id=%0d resp=%0d exp 7/1", rsp_id, rsp_resp); end
        repeat (3) @(negedge AClk);
        #1;
        checks++; if (err_unexp_b !== 1'b1 || outst_cnt !== '0) begin errors++; $display("FAIL unexp_sticky got err=%0h outst=%0d exp 1/0", err_unexp_b, outst_cnt); end
    endtask

    task automatic test_reset_midburst();
        bit ok; int seen, nlast, lidx, dbad;
        axi_if.AWREADY = 1'b0;
        drive_cmd(32'h5000, 8'd7, 3'd3, 2'b01, 4'd2, 4, ok);
        run_w(2, 1'b0, seen, nlast, lidx, dbad);
        checks++; if (!ok || seen !== 2 || nlast !== 0 || axi_if.AWVALID !== 1'b1) begin errors++; $display("FAIL mid_pre got ok=%0d beats=%0d lasts=%0d awv=%0h exp 1/2/0/1", ok, seen, nlast, axi_if.AWVALID); end
        ARst = 1'b0;
        wd_valid = 1'b1;
        @(negedge AClk); #1;
        checks++; if (axi_if.AWVALID !== 1'b0 || axi_if.WVALID !== 1'b0 || axi_if.WLAST !== 1'b0) begin errors++; $display("FAIL mid_rst_ch got awv=%0h wv=%0h wl=%0h exp 0/0/0", axi_if.AWVALID, axi_if.WVALID, axi_if.WLAST); end
        checks++; if (outst_cnt !== '0 || err_unexp_b !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_state got outst=%0d err=%0h rv=%0h exp 0/0/0", outst_cnt, err_unexp_b, rsp_valid); end
        checks++; if (axi_if.AWADDR !== '0 || axi_if.AWLEN !== '0 || axi_if.AWID !== '0 || rsp_id !== '0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_fields got a=%0h l=%0d id=%0d rid=%0d rdy=%0h exp 0/0/0/0/1", axi_if.AWADDR, axi_if.AWLEN, axi_if.AWID, rsp_id, cmd_ready); end
        wd_valid = 1'b0;
        ARst = 1'b1;
        axi_if.AWREADY = 1'b1;
        drive_cmd(32'h3000, 8'd1, 3'd3, 2'b01, 4'd9, 4, ok);
        #1;
        checks++; if (!ok || axi_if.AWVALID !== 1'b1 || axi_if.AWADDR !== 32'h3000) begin errors++; $display("FAIL mid_new_aw got ok=%0d v=%0h a=%0h exp 1/1/3000", ok, axi_if.AWVALID, axi_if.AWADDR); end
        run_w(2, 1'b0, seen, nlast, lidx, dbad);
        checks++; if (seen !== 2 || nlast !== 1 || lidx !== 2 || dbad !== 0) begin errors++; $display("FAIL mid_new_w got beats=%0d lasts=%0d lastbeat=%0d bad=%0d exp 2/1/2/0", seen, nlast, lidx, dbad); end
        send_b(4'd9, 2'b00, 4, ok);
        #1;
        checks++; if (!ok || rsp_id !== 4'd9 || outst_cnt !== '0) begin errors++; $display("FAIL mid_new_rsp got ok=%0d id=%0d outst=%0d exp 1/9/0", ok, rsp_id, outst_cnt); end
    endtask

    task automatic test_boundary();
        bit ok; bit seen_rsp;
        do_reset();
        axi_if.AWREADY = 1'b0;
        drive_cmd(32'h0FF8, 8'd1, 3'd3, 2'b01, 4'd6, 4, ok);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL bnd_accept got 0 exp 1"); end
`ifdef WR_BOUNDARY_CHECK_EN
        checks++; if (axi_if.AWVALID !== 1'b0 || outst_cnt !== '0) begin errors++; $display("FAIL bnd_no_aw got awv=%0h outst=%0d exp 0/0", axi_if.AWVALID, outst_cnt); end
        seen_rsp = 1'b0;
        for (int i = 0; i < 4 && !seen_rsp; i++) begin
            if (rsp_valid === 1'b1) seen_rsp = 1'b1;
            else begin @(negedge AClk); #1; end
        end
        checks++; if (!seen_rsp || rsp_id !== 4'd6 || rsp_resp !== 2'b10) begin errors++; $display("FAIL bnd_local_rsp got v=%0d id=%0d resp=%0d exp 1/6/2", seen_rsp, rsp_id, rsp_resp); end
        wd_valid = 1'b1;
        #1;
        checks++; if (axi_if.WVALID !== 1'b0) begin errors++; $display("FAIL bnd_no_fifo got %0h exp 0", axi_if.WVALID); end
        wd_valid = 1'b0;
`else
        seen_rsp = 1'b0;
        checks++; if (axi_if.AWVALID !== 1'b1 || axi_if.AWADDR !== 32'h0FF8 || outst_cnt !== 3'd1 || seen_rsp) begin errors++; $display("FAIL bnd_issued got awv=%0h a=%0h outst=%0d exp 1/ff8/1", axi_if.AWVALID, axi_if.AWADDR, outst_cnt); end
`endif
    endtask

    initial begin
        ARst = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0; cmd_id = '0;
        wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rsp_ready = 1'b1;
        axi_if.AWREADY = 1'b1; axi_if.WREADY = 1'b1; axi_if.BVALID = 1'b0;
        axi_if.BID = '0; axi_if.BRESP = '0;
        test_reset();
        test_single_burst();
        test_outstanding_limit();
        test_backpressure();
        test_rsp_stall();
        test_unexp_b();
        test_reset_midburst();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
